id_stage: RTL and testbench

- Decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
- Contains the IF/ID pipeline latch, a 32x32 register file with a write-back port, the main control decoder and sign-extension.
- Contains load-use hazard detection and the ID/EX output register.
- Consumes the fetched word and next-PC from fetch; feeds the execute stage; returns a stall to fetch.

---
 rtl/mips_pkg.sv | 88 ++++++++
 rtl/regfile.sv | 55 +++++
 rtl/id_stage.sv | 141 ++++++++++++++
 tb/tb_id_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct and control-word definitions shared by the
// stages of the 5-stage MIPS pipeline, plus the main control decoder.
package mips_pkg;

  // Register index width (32 architectural registers).
  localparam int REG_AW = 5;

  // Width of the packed control word carried from ID to EX.
  localparam int CTRL_W = 10;

  // Primary opcodes handled by the decoder (instr[31:26]).
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  // R-type funct codes (instr[5:0]); ID passes funct through unchecked.
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALU operation classes handed to the EX-stage ALU control.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Bit positions inside the control word:
  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
  //  branch, alu_op[1:0], illegal}
  localparam int CTRL_REG_DST    = 9;
  localparam int CTRL_ALU_SRC    = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_MEM_WRITE  = 4;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_ALU_OP_HI  = 2;
  localparam int CTRL_ALU_OP_LO  = 1;
  localparam int CTRL_ILLEGAL    = 0;

  // Control word of a pipeline bubble: no side effects anywhere downstream.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // Main control decoder. Unknown opcodes produce only the illegal flag so
  // that EX/exception logic can decide what to do with them.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] opcode);
    logic [CTRL_W-1:0] c;
    c = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        c[CTRL_REG_DST]                   = 1'b1;
        c[CTRL_REG_WRITE]                 = 1'b1;
        c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]  = ALUOP_FUNCT;
      end
      OP_LW: begin
        c[CTRL_ALU_SRC]                   = 1'b1;
        c[CTRL_MEM_TO_REG]                = 1'b1;
        c[CTRL_REG_WRITE]                 = 1'b1;
        c[CTRL_MEM_READ]                  = 1'b1;
        c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]  = ALUOP_ADD;
      end
      OP_SW: begin
        c[CTRL_ALU_SRC]                   = 1'b1;
        c[CTRL_MEM_WRITE]                 = 1'b1;
        c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]  = ALUOP_ADD;
      end
      OP_BEQ: begin
        c[CTRL_BRANCH]                    = 1'b1;
        c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]  = ALUOP_SUB;
      end
      default: begin
        c[CTRL_ILLEGAL]                   = 1'b1;
      end
    endcase
    return c;
  endfunction

  // True when the instruction actually consumes its rt field as a source
  // operand; lw uses rt as a destination, so it cannot cause a rt hazard.
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32-entry architectural register file with two combinational
// read ports, one write port, write-first bypass and $0 hardwired to zero.
module regfile
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_a,
  output logic [XLEN-1:0]   rdata_b
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: cleared on reset, writes to $0 are silently dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Port A read: $0 reads zero, a same-cycle write to the same index wins.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      if (we && (waddr == raddr_a)) begin
        rdata_a = wdata;
      end else begin
        rdata_a = regs[raddr_a];
      end
    end
  end

  // Port B read: same rules as port A.
  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) begin
      if (we && (waddr == raddr_b)) begin
        rdata_b = wdata;
      end else begin
        rdata_b = regs[raddr_b];
      end
    end
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage of the 5-stage MIPS pipeline. Holds the IF/ID
// latch, the register file, the control decoder, load-use hazard detection
// and the ID/EX output register. A word accepted from fetch at one edge is
// visible on the id_* outputs after the following edge.
module id_stage
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_npc,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_npc,
  output logic [XLEN-1:0]   id_rs_data,
  output logic [XLEN-1:0]   id_rt_data,
  output logic [XLEN-1:0]   id_imm,
  output logic [REG_AW-1:0] id_rs,
  output logic [REG_AW-1:0] id_rt,
  output logic [REG_AW-1:0] id_rd,
  output logic [5:0]        id_funct,
  output logic [CTRL_W-1:0] id_ctrl
);

  // IF/ID latch contents.
  logic              ifid_valid;
  logic [XLEN-1:0]   ifid_instr;
  logic [XLEN-1:0]   ifid_npc;

  // Instruction fields of the word sitting in IF/ID.
  logic [5:0]        ifid_op;
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic [REG_AW-1:0] ifid_rd;
  logic [15:0]       ifid_imm16;
  logic [5:0]        ifid_funct;

  // Decoded values destined for ID/EX.
  logic [XLEN-1:0]   rs_rdata;
  logic [XLEN-1:0]   rt_rdata;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;

  logic              load_use;
  logic              bubble;

  assign ifid_op    = ifid_instr[31:26];
  assign ifid_rs    = ifid_instr[25:21];
  assign ifid_rt    = ifid_instr[20:16];
  assign ifid_rd    = ifid_instr[15:11];
  assign ifid_imm16 = ifid_instr[15:0];
  assign ifid_funct = ifid_instr[5:0];

  assign dec_ctrl = decode_ctrl(ifid_op);
  assign dec_imm  = {{(XLEN-16){ifid_imm16[15]}}, ifid_imm16};

  regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (ifid_rs),
    .raddr_b (ifid_rt),
    .rdata_a (rs_rdata),
    .rdata_b (rt_rdata)
  );

  // Load-use detection: a load in ID/EX whose destination is a source of
  // the instruction waiting in IF/ID must be separated by one bubble.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && id_ctrl[CTRL_MEM_READ] && (id_rt != '0) && ifid_valid) begin
      if (id_rt == ifid_rs) begin
        load_use = 1'b1;
      end else if ((id_rt == ifid_rt) && reads_rt(ifid_op)) begin
        load_use = 1'b1;
      end
    end
  end

  // A flush discards the consumer anyway, and reset drops any pending stall.
  assign stall = load_use && !flush && !rst;

  // ID/EX receives a bubble whenever IF/ID has nothing usable to hand over.
  assign bubble = flush || stall || !ifid_valid;

  // IF/ID latch: flush squashes, stall holds, otherwise capture fetch output.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_npc   <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_valid <= if_valid;
      ifid_instr <= if_instr;
      ifid_npc   <= if_npc;
    end
  end

  // ID/EX register: either a fully zeroed bubble or the decoded IF/ID word.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      id_valid   <= 1'b0;
      id_npc     <= '0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_imm     <= '0;
      id_rs      <= '0;
      id_rt      <= '0;
      id_rd      <= '0;
      id_funct   <= '0;
      id_ctrl    <= CTRL_BUBBLE;
    end else begin
      id_valid   <= 1'b1;
      id_npc     <= ifid_npc;
      id_rs_data <= rs_rdata;
      id_rt_data <= rt_rdata;
      id_imm     <= dec_imm;
      id_rs      <= ifid_rs;
      id_rt      <= ifid_rt;
      id_rd      <= ifid_rd;
      id_funct   <= ifid_funct;
      id_ctrl    <= dec_ctrl;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a
// behavioural model of the decode stage kept inside this bench.
module tb_id_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_instr = '0;
  logic [31:0] if_npc = '0;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_npc;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [5:0]  id_funct;
  logic [9:0]  id_ctrl;

  // Free-running clock.
  always #5 clk = ~clk;

  id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .if_instr   (if_instr),
    .if_npc     (if_npc),
    .if_valid   (if_valid),
    .flush      (flush),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall      (stall),
    .id_valid   (id_valid),
    .id_npc     (id_npc),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_funct   (id_funct),
    .id_ctrl    (id_ctrl)
  );

  int checks = 0;
  int failures = 0;
  int stall_count = 0;
  logic last_stall = 1'b0;

  // Model: architectural registers, the word waiting in decode, and the
  // instruction record expected to sit in the ID/EX output register.
  logic [31:0] m_regs [32];
  logic        m_if_valid;
  logic [31:0] m_if_instr;
  logic [31:0] m_if_npc;
  logic        m_stall;
  logic        e_valid;
  logic [5:0]  e_op;
  logic [31:0] e_npc, e_rs_data, e_rt_data, e_imm;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [5:0]  e_funct;
  logic [9:0]  e_ctrl;

  // Expected control word, listed per instruction class:
  // {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op,illegal}
  function automatic logic [9:0] expected_ctrl(input logic [5:0] op);
    case (op)
      OP_RTYPE: return 10'b1_0_0_1_0_0_0_10_0;
      OP_LW:    return 10'b0_1_1_1_1_0_0_00_0;
      OP_SW:    return 10'b0_1_0_0_0_1_0_00_0;
      OP_BEQ:   return 10'b0_0_0_0_0_0_1_01_0;
      default:  return 10'b0_0_0_0_0_0_0_00_1;
    endcase
  endfunction

  // Architectural read as seen during the current cycle.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && (wb_addr == a)) return wb_data;
    return m_regs[a];
  endfunction

  // The decode word must wait when the load in EX produces one of its sources.
  function automatic logic model_stall();
    logic [5:0] op;
    logic [4:0] src_rs, src_rt;
    logic       uses_rt;
    if (rst || flush) return 1'b0;
    op      = m_if_instr[31:26];
    src_rs  = m_if_instr[25:21];
    src_rt  = m_if_instr[20:16];
    uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    if (!(e_valid && (e_op == OP_LW) && (e_rt != 5'd0) && m_if_valid)) return 1'b0;
    return (e_rt == src_rs) || ((e_rt == src_rt) && uses_rt);
  endfunction

  // Advance the model across one rising edge.
  task automatic model_edge();
    logic [31:0] w;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_if_valid = 1'b0; m_if_instr = 32'd0; m_if_npc = 32'd0;
      e_valid = 1'b0; e_op = 6'd0; e_npc = 32'd0; e_rs_data = 32'd0; e_rt_data = 32'd0;
      e_imm = 32'd0; e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0; e_funct = 6'd0; e_ctrl = 10'd0;
      return;
    end
    w = m_if_instr;
    if (flush || m_stall || !m_if_valid) begin
      e_valid = 1'b0; e_op = 6'd0; e_npc = 32'd0; e_rs_data = 32'd0; e_rt_data = 32'd0;
      e_imm = 32'd0; e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0; e_funct = 6'd0; e_ctrl = 10'd0;
    end else begin
      e_valid   = 1'b1;
      e_op      = w[31:26];
      e_npc     = m_if_npc;
      e_rs      = w[25:21];
      e_rt      = w[20:16];
      e_rd      = w[15:11];
      e_funct   = w[5:0];
      e_imm     = 32'($signed(w[15:0]));
      e_rs_data = model_read(w[25:21]);
      e_rt_data = model_read(w[20:16]);
      e_ctrl    = expected_ctrl(w[31:26]);
    end
    if (wb_we && (wb_addr != 5'd0)) m_regs[wb_addr] = wb_data;
    if (flush) begin
      m_if_valid = 1'b0;
    end else if (!m_stall) begin
      m_if_valid = if_valid;
      m_if_instr = if_instr;
      m_if_npc   = if_npc;
    end
  endtask

  // One comparison point.
  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every registered output with the model.
  task automatic checkOutput();
    checkValue("id_valid",   32'(id_valid),   32'(e_valid));
    checkValue("id_npc",     id_npc,          e_npc);
    checkValue("id_rs_data", id_rs_data,      e_rs_data);
    checkValue("id_rt_data", id_rt_data,      e_rt_data);
    checkValue("id_imm",     id_imm,          e_imm);
    checkValue("id_rs",      32'(id_rs),      32'(e_rs));
    checkValue("id_rt",      32'(id_rt),      32'(e_rt));
    checkValue("id_rd",      32'(id_rd),      32'(e_rd));
    checkValue("id_funct",   32'(id_funct),   32'(e_funct));
    checkValue("id_ctrl",    32'(id_ctrl),    32'(e_ctrl));
  endtask

  // Drive one cycle of inputs (called at a falling edge), check the
  // combinational stall, cross the rising edge, then check the outputs.
  task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic [31:0] npc,
                               input logic v, input logic f, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
    rst = r; if_instr = instr; if_npc = npc; if_valid = v; flush = f;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    m_stall = model_stall();
    checkValue("stall", 32'(stall), 32'(m_stall));
    last_stall = stall;
    if (stall === 1'b1) stall_count++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [31:0] random_instr();
    logic [5:0]  functs [5];
    logic [5:0]  bad_ops [4];
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] w;
    functs  = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
    bad_ops = '{6'h3F, 6'h08, 6'h0D, 6'h02};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 4))
      0: begin op = OP_RTYPE; w = {op, rs, rt, rd, 5'd0, functs[$urandom_range(0, 4)]}; end
      1: begin op = OP_LW;    w = {op, rs, rt, imm}; end
      2: begin op = OP_SW;    w = {op, rs, rt, imm}; end
      3: begin op = OP_BEQ;   w = {op, rs, rt, imm}; end
      default: begin op = bad_ops[$urandom_range(0, 3)]; w = {op, rs, rt, imm}; end
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADD_9_8_8  = 32'h01084820;
  localparam logic [31:0] LW_11_16   = 32'h8E0B0004;
  localparam logic [31:0] SLT_12_11  = 32'h0168602A;
  localparam logic [31:0] ADD_9_0_0  = 32'h00004820;
  localparam logic [31:0] SW_16_16   = 32'hAE100008;
  localparam logic [31:0] ADD_8_9_0  = 32'h01204020;
  localparam logic [31:0] ILLEGAL_3F = 32'hFC221234;
  localparam logic [31:0] SW_IMM_C   = 32'hAC82000C;
  localparam logic [31:0] BEQ_NEG    = 32'h10228004;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence followed by a randomized phase.
  initial begin
    @(negedge clk);
    applyStimulus(1, 32'hDEADBEEF, 32'h10, 1, 0, 0, 0, 0);
    applyStimulus(1, 32'hDEADBEEF, 32'h10, 1, 0, 1, 5'd3, 32'h1);
    checkValue("reset_id_valid", 32'(id_valid), 32'd0);
    checkValue("reset_id_ctrl", 32'(id_ctrl), 32'd0);
    checkValue("reset_id_npc", id_npc, 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkValue("idle_id_valid", 32'(id_valid), 32'd0);
      checkValue("idle_id_ctrl", 32'(id_ctrl), 32'd0);
      checkValue("idle_stall", 32'(last_stall), 32'd0);
    end

    // add $9,$8,$8 with $8=5
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd8, 32'd5);
    applyStimulus(0, ADD_9_8_8, 32'd4, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("add_rs", 32'(id_rs), 32'd8);
    checkValue("add_rt", 32'(id_rt), 32'd8);
    checkValue("add_rd", 32'(id_rd), 32'd9);
    checkValue("add_rs_data", id_rs_data, 32'd5);
    checkValue("add_rt_data", id_rt_data, 32'd5);
    checkValue("add_funct", 32'(id_funct), 32'h20);
    checkValue("add_ctrl", 32'(id_ctrl), 32'h244);
    checkValue("add_alu_op", 32'(id_ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]), 32'(ALUOP_FUNCT));
    checkValue("add_npc", id_npc, 32'd4);

    // lw $11,4($16) with same-cycle write of $16, then dependent slt
    applyStimulus(0, LW_11_16, 32'd8, 1, 0, 0, 0, 0);
    applyStimulus(0, SLT_12_11, 32'd12, 1, 0, 1, 5'd16, 32'h100);
    checkValue("lw_bypass_rs_data", id_rs_data, 32'h100);
    checkValue("lw_imm", id_imm, 32'd4);
    checkValue("lw_ctrl", 32'(id_ctrl), 32'h1E0);
    checkValue("lw_alu_op", 32'(id_ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]), 32'(ALUOP_ADD));
    stall_count = 0;
    applyStimulus(0, ADD_9_8_8, 32'd16, 1, 0, 0, 0, 0);
    checkValue("loaduse_stall", 32'(last_stall), 32'd1);
    checkValue("loaduse_bubble_valid", 32'(id_valid), 32'd0);
    checkValue("loaduse_bubble_ctrl", 32'(id_ctrl), 32'd0);
    applyStimulus(0, ADD_9_8_8, 32'd16, 1, 0, 0, 0, 0);
    checkValue("slt_rs", 32'(id_rs), 32'd11);
    checkValue("slt_funct", 32'(id_funct), 32'(FUNCT_SLT));
    checkValue("slt_rt_data", id_rt_data, 32'd5);
    checkValue("loaduse_stall_cycles", 32'(stall_count), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // writes to $0 are ignored and never bypassed
    applyStimulus(0, ADD_9_0_0, 32'd20, 1, 0, 1, 5'd0, 32'hFFFF);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF);
    checkValue("r0_rs_data", id_rs_data, 32'd0);
    checkValue("r0_rt_data", id_rt_data, 32'd0);

    // flush squashes sw in decode; write-back during flush still lands
    applyStimulus(0, SW_16_16, 32'd24, 1, 0, 0, 0, 0);
    applyStimulus(0, ADD_8_9_0, 32'd28, 1, 1, 1, 5'd9, 32'h77);
    checkValue("flush_valid", 32'(id_valid), 32'd0);
    checkValue("flush_mem_write", 32'(id_ctrl[CTRL_MEM_WRITE]), 32'd0);
    applyStimulus(0, ADD_8_9_0, 32'd32, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("flush_wb_kept", id_rs_data, 32'h77);

    // flush during a load-use stall drops the stall immediately
    applyStimulus(0, LW_11_16, 32'd36, 1, 0, 0, 0, 0);
    applyStimulus(0, SLT_12_11, 32'd40, 1, 0, 0, 0, 0);
    applyStimulus(0, ADD_9_8_8, 32'd44, 1, 1, 0, 0, 0);
    checkValue("flush_stall", 32'(last_stall), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("flush_squash_slt", 32'(id_valid), 32'd0);

    // illegal opcode, positive and negative immediates
    applyStimulus(0, ILLEGAL_3F, 32'd48, 1, 0, 0, 0, 0);
    applyStimulus(0, SW_IMM_C, 32'd52, 1, 0, 0, 0, 0);
    checkValue("illegal_valid", 32'(id_valid), 32'd1);
    checkValue("illegal_ctrl", 32'(id_ctrl), 32'h001);
    checkValue("illegal_flag", 32'(id_ctrl[CTRL_ILLEGAL]), 32'd1);
    applyStimulus(0, BEQ_NEG, 32'd56, 1, 0, 0, 0, 0);
    checkValue("sw_imm", id_imm, 32'h0000000C);
    checkValue("sw_ctrl", 32'(id_ctrl), 32'h110);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("beq_imm", id_imm, 32'hFFFF8004);
    checkValue("beq_ctrl", 32'(id_ctrl), 32'h00A);
    checkValue("beq_alu_op", 32'(id_ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]), 32'(ALUOP_SUB));

    // reset in the middle of a load-use stall
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd8, 32'h55);
    applyStimulus(0, LW_11_16, 32'd60, 1, 0, 0, 0, 0);
    applyStimulus(0, SLT_12_11, 32'd64, 1, 0, 0, 0, 0);
    applyStimulus(1, ADD_9_8_8, 32'd68, 1, 0, 0, 0, 0);
    checkValue("midreset_stall", 32'(last_stall), 32'd0);
    checkValue("midreset_valid", 32'(id_valid), 32'd0);
    applyStimulus(0, ADD_9_8_8, 32'd72, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("midreset_regs_cleared", id_rs_data, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), random_instr(), $urandom,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
